multicycle_controller: RTL and testbench

Control unit for the multicycle ARM datapath. It replaces the single-cycle `controller` once instruction and data memory are merged into one shared memory. The block holds the main state machine, the ALU decoder, the NZCV flag registers and the condition-evaluation logic. Each cycle it drives the datapath strobes and mux selects, sequencing every instruction over 3–5 cycles.

---
 rtl/multicycle_controller.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller : multicycle ARM control unit (FSM, ALU decode, NZCV)
// Revision 1.0
// ============================================================================
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     r_state;
  logic [3:0] r_flags;
  logic       r_condl;

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic       w_n, w_z, w_c, w_v;
  logic       w_condex;
  logic [2:0] w_aluctl;
  logic       w_cv_op;
  logic       w_pcw, w_memw, w_irw, w_regw;
  logic       w_unused;

  // Instr carries bits [31:12] of the instruction word
  assign w_cond   = Instr[19:16];
  assign w_op     = Instr[15:14];
  assign w_funct  = Instr[13:8];
  assign w_rd     = Instr[3:0];
  assign w_unused = ^Instr[7:4];

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_condex = 1'b0;
    case (w_cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = (w_n == w_v);
      4'b1011: w_condex = (w_n != w_v);
      4'b1100: w_condex = ~w_z & (w_n == w_v);
      4'b1101: w_condex = w_z | (w_n != w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  always_comb begin
    w_aluctl = 3'b000;
    case (w_funct[4:1])
      4'b0100: w_aluctl = 3'b000;
      4'b0010: w_aluctl = 3'b001;
      4'b0000: w_aluctl = 3'b010;
      4'b1100: w_aluctl = 3'b011;
      4'b0001: w_aluctl = 3'b101;
      default: w_aluctl = 3'b000;
    endcase
  end

  // Unrecognised commands decode to ADD, so they update C and V as well
  assign w_cv_op = (w_aluctl == 3'b000) || (w_aluctl == 3'b001);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
      r_flags <= 4'b0000;
      r_condl <= 1'b0;
    end else begin
      case (r_state)
        FETCH: r_state <= DECODE;
        DECODE: begin
          r_condl <= w_condex;
          case (w_op)
            2'b00:   r_state <= w_funct[5] ? EXECUTEI : EXECUTER;
            2'b01:   r_state <= MEMADR;
            2'b10:   r_state <= BRANCH;
            default: r_state <= FETCH;
          endcase
        end
        MEMADR:  r_state <= w_funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD: r_state <= MEMWB;
        EXECUTER, EXECUTEI: begin
          r_state <= ALUWB;
          if (r_condl && w_funct[0]) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_cv_op)
              r_flags[1:0] <= ALUFlags[1:0];
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    w_pcw      = 1'b0;
    w_memw     = 1'b0;
    w_irw      = 1'b0;
    w_regw     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    case (r_state)
      FETCH: begin
        w_irw     = 1'b1;
        w_pcw     = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:  ALUSrcB = 2'b01;
      MEMREAD: AdrSrc  = 1'b1;
      MEMWRITE: begin
        AdrSrc = 1'b1;
        w_memw = r_condl;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = r_condl;
        w_pcw     = r_condl & (w_rd == 4'd15);
      end
      EXECUTER: ALUControl = w_aluctl;
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = w_aluctl;
      end
      ALUWB: begin
        w_regw = r_condl;
        w_pcw  = r_condl & (w_rd == 4'd15);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_pcw     = r_condl;
      end
      default: ;
    endcase
  end

  // Write strobes are held off for as long as reset is low
  assign PCWrite  = reset & w_pcw;
  assign MemWrite = reset & w_memw;
  assign IRWrite  = reset & w_irw;
  assign RegWrite = reset & w_regw;

  assign ImmSrc = w_op;
  assign RegSrc = {(w_op == 2'b01) & ~w_funct[0], (w_op == 2'b10)};
  assign State  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// tb_multicycle_controller : directed scoreboard bench for multicycle_controller
// Revision 1.0
// ============================================================================
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .State      (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [20:0] v;
  } exp_t;

  exp_t        q[$];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [1:0]  exp_imm;
  logic [1:0]  exp_regsrc;
  logic [20:0] act;

  assign act = {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite};

  // Monitor: every cycle with a pending expectation is compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp_cnt++;
      if (act !== e.v) begin
        err_cnt++;
        $display("FAIL %s: got st=%0d vec=%h, expected st=%0d vec=%h",
                 e.nm, act[20:17], act, e.v[20:17], e.v);
      end
    end
  end

  // Push one cycle's expected outputs, then advance to just after the next edge
  task automatic cyc(input string nm, input logic [3:0] st, input logic pcw,
                     input logic adr, input logic memw, input logic irw,
                     input logic [1:0] res, input logic srca, input logic [1:0] srcb,
                     input logic [2:0] aluc, input logic regw);
    exp_t e;
    e.nm = nm;
    e.v  = {st, pcw, adr, memw, irw, res, srca, srcb, aluc, exp_imm, exp_regsrc, regw};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [19:0] ins, input logic [1:0] imm,
                           input logic [1:0] rsrc);
    Instr      = ins;
    exp_imm    = imm;
    exp_regsrc = rsrc;
  endtask

  task automatic t_fetch(input string nm);
    cyc(nm, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 3'b000, 1'b0);
  endtask

  task automatic t_decode(input string nm);
    cyc(nm, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 3'b000, 1'b0);
  endtask

  task automatic t_rst(input string nm);
    cyc(nm, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 3'b000, 1'b0);
  endtask

  // Branch with Cond nibble c; taken selects the expected PCWrite in BRANCH
  task automatic branch(input string nm, input logic [3:0] c, input logic taken);
    set_instr({c, 16'hA000}, 2'b10, 2'b01);
    t_fetch({nm, "_f"});
    t_decode({nm, "_d"});
    cyc(nm, 4'd9, taken, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 3'b000, 1'b0);
  endtask

  // Load/store: ins is the instruction, load selects LDR, strobe is the expected gated strobe
  task automatic memop(input string nm, input logic [19:0] ins, input logic [1:0] rsrc,
                       input logic load, input logic strobe, input logic pcw);
    set_instr(ins, 2'b01, rsrc);
    t_fetch({nm, "_f"});
    t_decode({nm, "_d"});
    cyc({nm, "_adr"}, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0);
    if (load) begin
      cyc({nm, "_rd"}, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0);
      cyc({nm, "_wb"}, 4'd4, pcw, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 3'b000, strobe);
    end else begin
      cyc({nm, "_wr"}, 4'd5, 1'b0, 1'b1, strobe, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0);
    end
  endtask

  // Data-processing: imm selects EXECUTEI, flags is ALUFlags during execute
  task automatic dp(input string nm, input logic [19:0] ins, input logic imm,
                    input logic [2:0] aluc, input logic [3:0] flags, input logic regw);
    set_instr(ins, 2'b00, 2'b00);
    t_fetch({nm, "_f"});
    t_decode({nm, "_d"});
    ALUFlags = flags;
    cyc({nm, "_ex"}, imm ? 4'd7 : 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
        imm ? 2'b01 : 2'b00, aluc, 1'b0);
    ALUFlags = 4'b0000;
    cyc({nm, "_wb"}, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, regw);
  endtask

  initial begin
    reset    = 1'b0;
    ALUFlags = 4'b0000;
    set_instr(20'h00000, 2'b00, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    t_rst("rst_hold");
    reset = 1'b1;

    // ADDS R1,R2,#5 -> flags NZCV = 0110
    dp("adds", 20'hE2921, 1'b1, 3'b000, 4'b0110, 1'b1);
    branch("beq_z1", 4'h0, 1'b1);

    memop("ldr",    20'hE5921, 2'b00, 1'b1, 1'b1, 1'b0);
    memop("ldr_pc", 20'hE592F, 2'b00, 1'b1, 1'b1, 1'b1);

    // ANDS with 1011: N=1, Z=0 written, C=1/V=0 retained -> 1010
    dp("ands", 20'hE0123, 1'b0, 3'b010, 4'b1011, 1'b1);
    branch("bne_z0", 4'h1, 1'b1);
    branch("beq_z0", 4'h0, 1'b0);
    branch("bvs",    4'h6, 1'b0);
    branch("bmi",    4'h4, 1'b1);
    branch("bcs",    4'h2, 1'b1);

    memop("streq_fail", 20'h05821, 2'b10, 1'b0, 1'b0, 1'b0);
    memop("str",        20'hE5821, 2'b10, 1'b0, 1'b1, 1'b0);

    // EORS with failed condition: no register or flag write
    dp("eorseq", 20'h00312, 1'b0, 3'b101, 4'b0100, 1'b0);
    branch("beq_after_eor", 4'h0, 1'b0);
    // SUB without S: flags stay 1010
    dp("sub", 20'hE0412, 1'b0, 3'b001, 4'b1111, 1'b1);
    branch("bvs_after_sub", 4'h6, 1'b0);

    // Undefined op: FETCH, DECODE, back to FETCH
    set_instr(20'hEC000, 2'b11, 2'b00);
    t_fetch("undef_f");
    t_decode("undef_d");

    // ORR, asynchronous reset in the middle of EXECUTER
    set_instr(20'hE1812, 2'b00, 2'b00);
    t_fetch("orr_f");
    t_decode("orr_d");
    #2;
    reset = 1'b0;
    t_rst("rst_async");
    t_rst("rst_hold2");
    reset = 1'b1;
    // Flags cleared by reset: C=0 so BCS falls through
    branch("bcs_after_rst", 4'h2, 1'b0);

    @(negedge clk);
    #1;
    cmp_cnt++;
    if (q.size() != 0) begin
      err_cnt++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
